up_dn_cmd_ctrl: RTL and testbench
=================================

Name: up_dn_cmd_ctrl

Overview:
Front-end command stage that sits directly upstream of the 5-bit up/down counter.
- Converts raw push-buttons (up, down, load) and a switch bank into clean single-cycle load/Down/Up pulses and a load value IN.
- Synchronises and debounces each button, detects presses, arbitrates them, and generates auto-repeat while up/down is held.
- Uses the counter's High/Low flags to stop pulsing at the limits.

Parameters:
WIDTH, 5, width of sw_val and IN; must match the counter width.
DB_CYCLES, 16, number of consecutive stable synchronised samples needed to change a debounced level (>=1).
RPT_DELAY, 64, cycles from the first pulse to the first repeat pulse; 0 disables auto-repeat (otherwise >=RPT_PERIOD).
RPT_PERIOD, 8, cycles between repeat pulses (>=1).

Ports:
CLK  in  1  system clock
rst_n  in  1  reset
btn_up  in  1  raw up button, asynchronous, active-high
btn_down  in  1  raw down button, asynchronous, active-high
btn_load  in  1  raw load button, asynchronous, active-high
sw_val  in  WIDTH  load value switches, quasi-static, sampled only on a load press
High  in  1  counter at maximum (from the counter)
Low  in  1  counter at zero (from the counter)
load  out  1  one-cycle load pulse to the counter
Up  out  1  one-cycle increment pulse
Down  out  1  one-cycle decrement pulse
IN  out  WIDTH  registered load value, valid while load=1 and held afterwards

Behaviour:
- Reset: rst_n is an asynchronous, active-low reset; clock is CLK.
  - While rst_n=0: load=Up=Down=0, IN=0, synchroniser and debounced levels 0, all counters 0, FSM=IDLE.
  - Reset mid-operation aborts everything immediately.
  - A button still held when reset is released counts as a new press after normal debounce.
- Input path, per button:
  - 2-FF synchroniser.
  - Debounce counter: counts while the synchronised level differs from the debounced level, clears on any match.
  - At DB_CYCLES the debounced level toggles and the counter clears.
  - Rise = debounced level is 1 now and was 0 the previous cycle.
- Latency: raw input stable from before edge 0 -> debounced high after edge 2+DB_CYCLES -> pulse output high for exactly the one cycle after edge 3+DB_CYCLES.
- All outputs are registered. At most one of load/Up/Down is high in any cycle.
- Priority, matching the counter: load > Down > Up.
- Load:
  - On load rise: load=1 for one cycle and IN<=sw_val on the same edge.
  - The FSM goes to IDLE, cancelling any repeat.
  - Up/down rises in that same cycle are dropped.
- Up/down FSM states: IDLE, HOLD_WAIT(dir), REPEAT(dir), where dir is UP or DN.
  - IDLE: on down rise -> pulse Down, dir=DN, rpt_cnt=0, go to HOLD_WAIT. Otherwise on up rise -> pulse Up, dir=UP, same.
  - HOLD_WAIT: rpt_cnt increments each cycle. When rpt_cnt=RPT_DELAY-1 -> pulse, rpt_cnt=0, go to REPEAT.
  - REPEAT: pulse when rpt_cnt=RPT_PERIOD-1, then rpt_cnt=0.
  - Debounced release of the dir button in HOLD_WAIT or REPEAT -> IDLE, with no pulse that cycle.
  - Both up and down debounced high at once (conflict) in any state -> IDLE, no pulse. A new press is needed; a held button does not re-trigger.
  - RPT_DELAY=0: HOLD_WAIT waits only for release, then -> IDLE.
- Limit gating:
  - An Up pulse that would issue while High=1 is suppressed; a Down pulse while Low=1 is suppressed.
  - The FSM and counters advance as if the pulse were issued, so repeat resumes when the flag drops (e.g. after a load).
- Widths:
  - Debounce counter: clog2(DB_CYCLES+1) bits.
  - rpt_cnt: clog2(max(RPT_DELAY,RPT_PERIOD)+1) bits.
  - No wrap-around: counters clear before overflow.

Decomposition:
- Package up_dn_pkg:
  - enum cmd_state_t {IDLE, HOLD_WAIT, REPEAT}
  - enum dir_t {DIR_UP, DIR_DN}
  - default constants CNT_WIDTH=5, DB_CYCLES_DEF, RPT_DELAY_DEF, RPT_PERIOD_DEF
- Sub-module btn_debounce (synchroniser + debounce counter + rise detect; outputs level and rise), instantiated three times.
- FSM, arbitration and output registers live in the top module.

Test Plan:
Bench parameters: DB_CYCLES=4, RPT_DELAY=10, RPT_PERIOD=3.
1. Reset/idle: assert rst_n=0 mid-repeat, then release with all buttons low -> load=Up=Down=0 and IN=0 immediately, no pulses for 50 cycles.
2. Bounce: btn_up toggles every 2 cycles for 20 cycles, then holds 1 for 3 cycles and releases -> no Up pulse. Clean press held 6 cycles -> exactly one Up pulse, 7 cycles after the raw rise.
3. Load: sw_val=5'h15, press btn_load -> one load pulse with IN=5'h15. Then change sw_val to 5'h03 -> IN stays 5'h15.
4. Auto-repeat: hold btn_down 40 cycles with Low=0 -> Down pulses at t0, t0+10, t0+13, t0+16, ..., stopping within 1 cycle of debounced release.
5. Limit and priority:
   - Hold btn_up with High=1 -> no Up pulses; drop High -> pulses resume on the next RPT_PERIOD boundary.
   - Up and load rises in the same cycle -> only load.
6. Conflict: hold up, then press down -> FSM goes IDLE, no pulses while both are held. Release down with up still held -> no pulse until up is re-pressed.

Source files
------------

// File: rtl/up_dn_pkg.sv
// Shared types and default sizing for the up/down counter command front end.
package up_dn_pkg;

    localparam int unsigned CNT_WIDTH      = 5;
    localparam int unsigned DB_CYCLES_DEF  = 16;
    localparam int unsigned RPT_DELAY_DEF  = 64;
    localparam int unsigned RPT_PERIOD_DEF = 8;

    typedef enum logic [1:0] {IDLE, HOLD_WAIT, REPEAT} cmd_state_t;
    typedef enum logic {DIR_UP, DIR_DN} dir_t;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// One push-button input path: 2-FF synchroniser, stability counter and rising-edge detect
// on the debounced level.
module btn_debounce #(
    parameter int unsigned DB_CYCLES = 16
) (
    input  logic CLK,
    input  logic rst_n,
    input  logic btn_i,
    output logic level_o,
    output logic rise_o
);

    localparam int unsigned   DW      = $clog2(DB_CYCLES + 1);
    localparam logic [DW-1:0] DB_LAST = DW'(DB_CYCLES);

    logic          sync1_q;
    logic          sync2_q;
    logic          level_q;
    logic          level_d;
    logic          level_prev_q;
    logic [DW-1:0] cnt_q;
    logic [DW-1:0] cnt_d;

    // Counter runs only while the synchronised input disagrees with the debounced level.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == DB_LAST) begin
                level_d = ~level_q;
            end else begin
                cnt_d = cnt_q + DW'(1);
            end
        end
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            level_q      <= 1'b0;
            level_prev_q <= 1'b0;
            cnt_q        <= '0;
        end else begin
            sync1_q      <= btn_i;
            sync2_q      <= sync1_q;
            level_q      <= level_d;
            level_prev_q <= level_q;
            cnt_q        <= cnt_d;
        end
    end

    assign level_o = level_q;
    assign rise_o  = level_q & ~level_prev_q;

endmodule

// File: rtl/up_dn_cmd_ctrl.sv
// Turns raw up/down/load buttons into single-cycle counter commands with auto-repeat
// and High/Low limit gating. Priority load > Down > Up.
module up_dn_cmd_ctrl
    import up_dn_pkg::*;
#(
    parameter int unsigned WIDTH      = CNT_WIDTH,
    parameter int unsigned DB_CYCLES  = DB_CYCLES_DEF,
    parameter int unsigned RPT_DELAY  = RPT_DELAY_DEF,
    parameter int unsigned RPT_PERIOD = RPT_PERIOD_DEF
) (
    input  logic             CLK,
    input  logic             rst_n,
    input  logic             btn_up,
    input  logic             btn_down,
    input  logic             btn_load,
    input  logic [WIDTH-1:0] sw_val,
    input  logic             High,
    input  logic             Low,
    output logic             load,
    output logic             Up,
    output logic             Down,
    output logic [WIDTH-1:0] IN
);

    localparam int unsigned   RW          = $clog2(max_u(RPT_DELAY, RPT_PERIOD) + 1);
    localparam logic [RW-1:0] DELAY_LAST  = RW'((RPT_DELAY > 0) ? RPT_DELAY - 1 : 0);
    localparam logic [RW-1:0] PERIOD_LAST = RW'(RPT_PERIOD - 1);

    logic up_lvl, up_rise;
    logic dn_lvl, dn_rise;
    logic ld_rise;
    logic unused_ld_lvl;

    cmd_state_t       state_q, state_d;
    dir_t             dir_q, dir_d;
    logic [RW-1:0]    rpt_cnt_q, rpt_cnt_d;
    logic             load_q, load_d;
    logic             up_q, up_d;
    logic             dn_q, dn_d;
    logic [WIDTH-1:0] in_q, in_d;
    logic             fire;
    logic             dir_lvl;

    btn_debounce #(
        .DB_CYCLES (DB_CYCLES)
    ) u_db_up (
        .CLK     (CLK),
        .rst_n   (rst_n),
        .btn_i   (btn_up),
        .level_o (up_lvl),
        .rise_o  (up_rise)
    );

    btn_debounce #(
        .DB_CYCLES (DB_CYCLES)
    ) u_db_dn (
        .CLK     (CLK),
        .rst_n   (rst_n),
        .btn_i   (btn_down),
        .level_o (dn_lvl),
        .rise_o  (dn_rise)
    );

    btn_debounce #(
        .DB_CYCLES (DB_CYCLES)
    ) u_db_ld (
        .CLK     (CLK),
        .rst_n   (rst_n),
        .btn_i   (btn_load),
        .level_o (unused_ld_lvl),
        .rise_o  (ld_rise)
    );

    assign dir_lvl = (dir_q == DIR_UP) ? up_lvl : dn_lvl;

    always_comb begin
        state_d   = state_q;
        dir_d     = dir_q;
        rpt_cnt_d = rpt_cnt_q;
        in_d      = in_q;
        load_d    = 1'b0;
        fire      = 1'b0;

        if (ld_rise) begin
            load_d    = 1'b1;
            in_d      = sw_val;
            state_d   = IDLE;
            rpt_cnt_d = '0;
        end else if (up_lvl && dn_lvl) begin
            // Conflict: drop to IDLE and wait for a fresh press.
            state_d   = IDLE;
            rpt_cnt_d = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (dn_rise) begin
                        fire      = 1'b1;
                        dir_d     = DIR_DN;
                        rpt_cnt_d = '0;
                        state_d   = HOLD_WAIT;
                    end else if (up_rise) begin
                        fire      = 1'b1;
                        dir_d     = DIR_UP;
                        rpt_cnt_d = '0;
                        state_d   = HOLD_WAIT;
                    end
                end
                HOLD_WAIT: begin
                    if (!dir_lvl) begin
                        state_d   = IDLE;
                        rpt_cnt_d = '0;
                    end else if (RPT_DELAY != 0) begin
                        if (rpt_cnt_q == DELAY_LAST) begin
                            fire      = 1'b1;
                            rpt_cnt_d = '0;
                            state_d   = REPEAT;
                        end else begin
                            rpt_cnt_d = rpt_cnt_q + RW'(1);
                        end
                    end
                end
                REPEAT: begin
                    if (!dir_lvl) begin
                        state_d   = IDLE;
                        rpt_cnt_d = '0;
                    end else if (rpt_cnt_q == PERIOD_LAST) begin
                        fire      = 1'b1;
                        rpt_cnt_d = '0;
                    end else begin
                        rpt_cnt_d = rpt_cnt_q + RW'(1);
                    end
                end
                default: begin
                    state_d   = IDLE;
                    rpt_cnt_d = '0;
                end
            endcase
        end

        // Limit flags only mask the pulse; the FSM timing carries on regardless.
        up_d = fire && (dir_d == DIR_UP) && !High;
        dn_d = fire && (dir_d == DIR_DN) && !Low;
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            dir_q     <= DIR_UP;
            rpt_cnt_q <= '0;
            load_q    <= 1'b0;
            up_q      <= 1'b0;
            dn_q      <= 1'b0;
            in_q      <= '0;
        end else begin
            state_q   <= state_d;
            dir_q     <= dir_d;
            rpt_cnt_q <= rpt_cnt_d;
            load_q    <= load_d;
            up_q      <= up_d;
            dn_q      <= dn_d;
            in_q      <= in_d;
        end
    end

    assign load = load_q;
    assign Up   = up_q;
    assign Down = dn_q;
    assign IN   = in_q;

endmodule

// File: tb/tb_up_dn_cmd_ctrl.sv
// Self-checking bench: directed scenarios plus random button activity, all outputs compared
// every cycle against a sample-window / elapsed-time reference model.
module tb_up_dn_cmd_ctrl;

    localparam int W  = 5;
    localparam int DB = 4;
    localparam int RD = 10;
    localparam int RP = 3;

    logic         CLK      = 1'b0;
    logic         rst_n    = 1'b1;
    logic         btn_up   = 1'b0;
    logic         btn_down = 1'b0;
    logic         btn_load = 1'b0;
    logic [W-1:0] sw_val   = '0;
    logic         High     = 1'b0;
    logic         Low      = 1'b0;
    logic         load;
    logic         Up;
    logic         Down;
    logic [W-1:0] IN;

    up_dn_cmd_ctrl #(
        .WIDTH      (W),
        .DB_CYCLES  (DB),
        .RPT_DELAY  (RD),
        .RPT_PERIOD (RP)
    ) dut (
        .CLK      (CLK),
        .rst_n    (rst_n),
        .btn_up   (btn_up),
        .btn_down (btn_down),
        .btn_load (btn_load),
        .sw_val   (sw_val),
        .High     (High),
        .Low      (Low),
        .load     (load),
        .Up       (Up),
        .Down     (Down),
        .IN       (IN)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Reference model state: raw-sample history per button (0 up, 1 down, 2 load).
    logic [DB+2:0] hist [3];
    bit   [2:0]    m_lvl;
    bit   [2:0]    m_rise;
    int            m_act;   // 0 none, 1 up, 2 down
    int            m_t0;
    bit            e_load, e_up, e_dn;
    logic [W-1:0]  e_in;

    int           up_at[$];
    int           dn_at[$];
    int           ld_at[$];
    logic [W-1:0] ld_in[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got %0h, expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) hist[i] = '0;
        m_lvl  = '0;
        m_rise = '0;
        m_act  = 0;
        m_t0   = 0;
        e_load = 1'b0;
        e_up   = 1'b0;
        e_dn   = 1'b0;
        e_in   = '0;
    endtask

    // Command decision for the current cycle; takes effect on the outputs after the next edge.
    task automatic decide();
        bit fire;
        int k;
        fire   = 1'b0;
        e_load = 1'b0;
        e_up   = 1'b0;
        e_dn   = 1'b0;
        if (m_rise[2]) begin
            e_load = 1'b1;
            e_in   = sw_val;
            m_act  = 0;
        end else if (m_lvl[0] && m_lvl[1]) begin
            m_act = 0;
        end else if (m_act != 0) begin
            if (!m_lvl[m_act-1]) begin
                m_act = 0;
            end else begin
                k = cyc - m_t0;
                if (RD > 0 && k >= RD && ((k - RD) % RP) == 0) fire = 1'b1;
            end
        end else if (m_rise[1]) begin
            m_act = 2;
            m_t0  = cyc;
            fire  = 1'b1;
        end else if (m_rise[0]) begin
            m_act = 1;
            m_t0  = cyc;
            fire  = 1'b1;
        end
        if (fire) begin
            e_up = (m_act == 1) && !High;
            e_dn = (m_act == 2) && !Low;
        end
    endtask

    task automatic tick();
        logic [2:0] raw;
        raw = {btn_load, btn_down, btn_up};
        decide();
        @(posedge CLK);
        #1;
        cyc++;
        // Level flips once DB+1 consecutive raw samples, seen through 2 sync stages, disagree.
        for (int i = 0; i < 3; i++) begin
            logic [DB:0] win;
            bit          nl;
            hist[i] = {hist[i][DB+1:0], raw[i]};
            win     = hist[i][DB+2:2];
            nl      = m_lvl[i];
            if (!m_lvl[i] && (&win)) nl = 1'b1;
            else if (m_lvl[i] && !(|win)) nl = 1'b0;
            m_rise[i] = nl & ~m_lvl[i];
            m_lvl[i]  = nl;
        end
        check_eq("load", load, e_load);
        check_eq("Up", Up, e_up);
        check_eq("Down", Down, e_dn);
        check_eq("IN", IN, e_in);
        check_eq("excl", $countones({load, Up, Down}) <= 1, 1);
        if (Up === 1'b1) up_at.push_back(cyc);
        if (Down === 1'b1) dn_at.push_back(cyc);
        if (load === 1'b1) begin
            ld_at.push_back(cyc);
            ld_in.push_back(IN);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic do_reset(input bit keep_btns);
        rst_n = 1'b0;
        #1;
        check_eq("rst_load", load, 0);
        check_eq("rst_Up", Up, 0);
        check_eq("rst_Down", Down, 0);
        check_eq("rst_IN", IN, 0);
        if (!keep_btns) begin
            btn_up   = 1'b0;
            btn_down = 1'b0;
            btn_load = 1'b0;
        end
        model_reset();
        repeat (2) @(posedge CLK);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        int b_up, b_dn, b_ld, press, exp_n;
        int hold [3];

        #2;
        do_reset(1'b0);
        idle(5);

        // Bouncing up button never yields a pulse.
        b_up = up_at.size();
        for (int i = 0; i < 20; i++) begin
            if (i % 2 == 0) btn_up = ~btn_up;
            tick();
        end
        btn_up = 1'b1;
        idle(3);
        btn_up = 1'b0;
        idle(20);
        check_eq("bounce_up_cnt", up_at.size() - b_up, 0);

        // Clean 6-cycle press: one Up, DB+3 edges after the first sampling edge.
        b_up   = up_at.size();
        btn_up = 1'b1;
        press  = cyc + 1;
        idle(6);
        btn_up = 1'b0;
        idle(20);
        check_eq("clean_up_cnt", up_at.size() - b_up, 1);
        if (up_at.size() > b_up) check_eq("clean_up_time", up_at[b_up], press + DB + 3);

        // Load captures switches; IN holds once the switches move.
        b_ld     = ld_at.size();
        sw_val   = 5'h15;
        btn_load = 1'b1;
        idle(10);
        btn_load = 1'b0;
        check_eq("load_cnt", ld_at.size() - b_ld, 1);
        if (ld_at.size() > b_ld) check_eq("load_IN", ld_in[b_ld], 5'h15);
        sw_val = 5'h03;
        idle(20);
        check_eq("IN_hold", IN, 5'h15);

        // Auto-repeat on a 40-cycle down hold.
        Low      = 1'b0;
        b_dn     = dn_at.size();
        btn_down = 1'b1;
        press    = cyc + 1;
        idle(40);
        btn_down = 1'b0;
        idle(20);
        exp_n = 1 + ((39 - RD) / RP + 1);
        check_eq("rpt_cnt", dn_at.size() - b_dn, exp_n);
        if (dn_at.size() >= b_dn + 3) begin
            check_eq("rpt_first", dn_at[b_dn], press + DB + 3);
            check_eq("rpt_delay", dn_at[b_dn+1] - dn_at[b_dn], RD);
            check_eq("rpt_period", dn_at[b_dn+2] - dn_at[b_dn+1], RP);
        end

        // High blocks Up pulses; repeat resumes after it drops.
        High   = 1'b1;
        b_up   = up_at.size();
        btn_up = 1'b1;
        idle(30);
        check_eq("high_block", up_at.size() - b_up, 0);
        High = 1'b0;
        idle(15);
        check_eq("high_resume", (up_at.size() - b_up) > 0, 1);
        btn_up = 1'b0;
        idle(20);

        // Up and load rising together: load only.
        b_up     = up_at.size();
        b_ld     = ld_at.size();
        sw_val   = 5'h0a;
        btn_up   = 1'b1;
        btn_load = 1'b1;
        idle(15);
        check_eq("prio_load", ld_at.size() - b_ld, 1);
        check_eq("prio_up", up_at.size() - b_up, 0);
        btn_up   = 1'b0;
        btn_load = 1'b0;
        idle(20);

        // Conflict: both held -> silent; held up does not re-trigger.
        btn_up = 1'b1;
        idle(15);
        btn_down = 1'b1;
        idle(8);
        b_up = up_at.size();
        b_dn = dn_at.size();
        idle(20);
        check_eq("conf_up", up_at.size() - b_up, 0);
        check_eq("conf_dn", dn_at.size() - b_dn, 0);
        btn_down = 1'b0;
        idle(8);
        b_up = up_at.size();
        idle(30);
        check_eq("conf_hold_up", up_at.size() - b_up, 0);
        btn_up = 1'b0;
        idle(10);
        b_up   = up_at.size();
        btn_up = 1'b1;
        idle(10);
        check_eq("conf_repress", up_at.size() - b_up, 1);
        btn_up = 1'b0;
        idle(20);

        // Reset in the middle of a repeat, released with buttons low.
        btn_down = 1'b1;
        idle(25);
        do_reset(1'b0);
        b_up = up_at.size();
        b_dn = dn_at.size();
        b_ld = ld_at.size();
        idle(50);
        check_eq("post_rst_pulses", (up_at.size() - b_up) + (dn_at.size() - b_dn)
                                    + (ld_at.size() - b_ld), 0);

        // Random button activity with varied hold lengths, flags and rare resets.
        for (int i = 0; i < 3; i++) hold[i] = $urandom_range(1, 60);
        repeat (4000) begin
            for (int i = 0; i < 3; i++) begin
                if (hold[i] == 0) begin
                    case (i)
                        0:       btn_up   = ~btn_up;
                        1:       btn_down = ~btn_down;
                        default: btn_load = ~btn_load;
                    endcase
                    hold[i] = (i == 2 && !btn_load) ? $urandom_range(20, 200)
                                                    : $urandom_range(1, 60);
                end else begin
                    hold[i]--;
                end
            end
            if ($urandom_range(0, 39) == 0) High = ~High;
            if ($urandom_range(0, 39) == 0) Low = ~Low;
            sw_val = W'($urandom);
            if ($urandom_range(0, 999) == 0) do_reset(1'b1);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
